// File: rtl/pipe_stage_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and debug-step enable. Optional bubble counter: PIPE_STAGE_BUBBLE_CNT_EN.
module pipe_stage_reg #(
    parameter int NB_CTRL = 12,
    parameter int NB_DATA = 148,
    parameter int NB_CNT  = 16
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic [NB_CTRL-1:0] i_ctrl,
    input  logic [NB_DATA-1:0] i_data,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [NB_CTRL-1:0] o_ctrl,
    output logic [NB_DATA-1:0] o_data,
    output logic [NB_CNT-1:0]  o_bubble_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [NB_CTRL-1:0] r_m_ctrl;
    logic [NB_DATA-1:0] r_m_data;
    logic [NB_CTRL-1:0] r_s_ctrl;
    logic [NB_DATA-1:0] r_s_data;

    logic w_m_valid;
    logic w_s_valid;
    logic w_acc;
    logic w_tak;
    logic w_load_main_in;
    logic w_load_main_skid;
    logic w_load_skid;

    assign w_m_valid = (r_state != EMPTY);
    assign w_s_valid = (r_state == FULL);

    // Ready is a function of registered occupancy only, which keeps it off the downstream path.
    assign o_ready = i_enable & ~w_s_valid & ~i_reset;
    assign o_valid = w_m_valid & i_enable;
    assign o_ctrl  = w_m_valid ? r_m_ctrl : '0;
    assign o_data  = r_m_data;

    assign w_acc = i_valid & o_ready;
    assign w_tak = o_valid & i_ready;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next     = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            w_state_next = EMPTY;
        end else if (i_enable) begin
            case (r_state)
                EMPTY: begin
                    if (w_acc) begin
                        w_state_next   = ONE;
                        w_load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (w_acc && w_tak) begin
                        w_load_main_in = 1'b1;
                    end else if (w_acc) begin
                        w_state_next = FULL;
                        w_load_skid  = 1'b1;
                    end else if (w_tak) begin
                        w_state_next = EMPTY;
                    end
                end
                FULL: begin
                    if (w_tak) begin
                        w_state_next     = ONE;
                        w_load_main_skid = 1'b1;
                    end
                end
                default: w_state_next = EMPTY;
            endcase
        end
    end

    // A flush turns the main entry into a bubble; data is left as-is since consumers ignore it.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_m_ctrl <= '0;
            r_m_data <= '0;
            r_s_ctrl <= '0;
            r_s_data <= '0;
        end else if (i_flush) begin
            r_m_ctrl <= '0;
        end else begin
            if (w_load_main_in) begin
                r_m_ctrl <= i_ctrl;
                r_m_data <= i_data;
            end else if (w_load_main_skid) begin
                r_m_ctrl <= r_s_ctrl;
                r_m_data <= r_s_data;
            end
            if (w_load_skid) begin
                r_s_ctrl <= i_ctrl;
                r_s_data <= i_data;
            end
        end
    end

`ifdef PIPE_STAGE_BUBBLE_CNT_EN
    logic [NB_CNT-1:0] r_bubble_cnt;

    // Saturating count of enabled cycles with nothing presented downstream; flush does not clear it.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_bubble_cnt <= '0;
        end else if (i_enable && !w_m_valid && (r_bubble_cnt != '1)) begin
            r_bubble_cnt <= r_bubble_cnt + {{(NB_CNT-1){1'b0}}, 1'b1};
        end
    end

    assign o_bubble_cnt = r_bubble_cnt;
`else
    assign o_bubble_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard testbench for pipe_stage_reg: directed handshake, backpressure, flush, freeze,
// async reset and bubble counter saturation (counter expected only with PIPE_STAGE_BUBBLE_CNT_EN).
module tb_pipe_stage_reg;

    localparam int NB_CTRL = 12;
    localparam int NB_DATA = 148;
    localparam int NB_CNT  = 2;
    localparam int NB_ENT  = NB_CTRL + NB_DATA;

    logic               i_clock;
    logic               i_reset;
    logic               i_enable;
    logic               i_flush;
    logic               i_valid;
    logic               o_ready;
    logic [NB_CTRL-1:0] i_ctrl;
    logic [NB_DATA-1:0] i_data;
    logic               o_valid;
    logic               i_ready;
    logic [NB_CTRL-1:0] o_ctrl;
    logic [NB_DATA-1:0] o_data;
    logic [NB_CNT-1:0]  o_bubble_cnt;

    int total = 0;
    int bad   = 0;

    logic [NB_ENT-1:0] sb[$];
    int                modelCnt = 0;

    pipe_stage_reg #(
        .NB_CTRL(NB_CTRL),
        .NB_DATA(NB_DATA),
        .NB_CNT (NB_CNT)
    ) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_enable    (i_enable),
        .i_flush     (i_flush),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_ctrl      (i_ctrl),
        .i_data      (i_data),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_ctrl      (o_ctrl),
        .o_data      (o_data),
        .o_bubble_cnt(o_bubble_cnt)
    );

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    task automatic checkOutput(input string tag, input logic [NB_ENT-1:0] obs,
                               input logic [NB_ENT-1:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int expBubble();
`ifdef PIPE_STAGE_BUBBLE_CNT_EN
        return modelCnt;
`else
        return 0;
`endif
    endfunction

    // One clock cycle: drive inputs after the falling edge, check against the model, then
    // advance the model by the transfers that the rising edge will commit.
    task automatic applyStimulus(input logic v, input logic r, input logic en, input logic fl,
                                 input logic [NB_CTRL-1:0] c, input logic [NB_DATA-1:0] d);
        logic expReady;
        logic expValid;
        @(negedge i_clock);
        i_valid  = v;
        i_ready  = r;
        i_enable = en;
        i_flush  = fl;
        i_ctrl   = c;
        i_data   = d;
        #2;
        expReady = en && (sb.size() < 2);
        expValid = en && (sb.size() > 0);
        checkOutput("ready", NB_ENT'(o_ready), NB_ENT'(expReady));
        checkOutput("valid", NB_ENT'(o_valid), NB_ENT'(expValid));
        if (expValid) begin
            checkOutput("entry", {o_ctrl, o_data}, sb[0]);
        end
        if (sb.size() == 0) begin
            checkOutput("bubble_ctrl", NB_ENT'(o_ctrl), '0);
        end
        checkOutput("bubble_cnt", NB_ENT'(o_bubble_cnt), NB_ENT'(expBubble()));
        if (expValid && r) void'(sb.pop_front());
        if (v && expReady && !fl) sb.push_back({c, d});
        if (fl) sb.delete();
        if (en && !expValid && modelCnt < (2 ** NB_CNT - 1)) modelCnt++;
        @(posedge i_clock);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_valid"}, NB_ENT'(o_valid), '0);
        checkOutput({tag, "_ready"}, NB_ENT'(o_ready), '0);
        checkOutput({tag, "_ctrl"}, NB_ENT'(o_ctrl), '0);
        checkOutput({tag, "_data"}, NB_ENT'(o_data), '0);
        checkOutput({tag, "_cnt"}, NB_ENT'(o_bubble_cnt), '0);
    endtask

    // Asserts reset between clock edges and releases it just after a rising edge.
    task automatic asyncReset();
        #2;
        i_reset = 1'b1;
        i_valid = 1'b0;
        #1;
        checkResetState("async_rst");
        sb.delete();
        modelCnt = 0;
        @(posedge i_clock);
        #1;
        checkOutput("rst_hold_ready", NB_ENT'(o_ready), '0);
        #2;
        i_reset = 1'b0;
        #1;
        checkOutput("rst_release_ready", NB_ENT'(o_ready), NB_ENT'(1'b1));
        checkOutput("rst_release_valid", NB_ENT'(o_valid), '0);
    endtask

    initial begin
        i_reset  = 1'b1;
        i_enable = 1'b1;
        i_flush  = 1'b0;
        i_valid  = 1'b0;
        i_ready  = 1'b0;
        i_ctrl   = '0;
        i_data   = '0;
        #2;
        checkResetState("init_rst");
        #5;
        i_reset = 1'b0;
        #1;
        checkOutput("init_release_ready", NB_ENT'(o_ready), NB_ENT'(1'b1));

        $display("[TB] streaming");
        applyStimulus(1, 1, 1, 0, 12'h0A5, 148'd1);
        applyStimulus(1, 1, 1, 0, 12'h0A5, 148'd2);
        applyStimulus(1, 1, 1, 0, 12'h0A5, 148'd3);
        applyStimulus(0, 1, 1, 0, 12'h000, 148'd0);
        applyStimulus(0, 1, 1, 0, 12'h000, 148'd0);

        $display("[TB] backpressure");
        applyStimulus(1, 0, 1, 0, 12'h011, 148'd1);
        applyStimulus(1, 0, 1, 0, 12'h022, 148'd2);
        applyStimulus(1, 0, 1, 0, 12'h033, 148'd3);
        applyStimulus(1, 0, 1, 0, 12'h033, 148'd3);
        applyStimulus(1, 1, 1, 0, 12'h033, 148'd3);
        applyStimulus(1, 1, 1, 0, 12'h033, 148'd3);
        applyStimulus(0, 1, 1, 0, 12'h000, 148'd0);
        applyStimulus(0, 1, 1, 0, 12'h000, 148'd0);

        $display("[TB] flush while full");
        applyStimulus(1, 0, 1, 0, 12'h055, 148'd5);
        applyStimulus(1, 0, 1, 0, 12'h066, 148'd6);
        applyStimulus(0, 0, 1, 1, 12'h000, 148'd0);
        applyStimulus(0, 1, 1, 0, 12'h000, 148'd0);
        applyStimulus(1, 1, 1, 1, 12'h088, 148'd8);
        applyStimulus(0, 1, 1, 0, 12'h000, 148'd0);

        $display("[TB] debug freeze");
        applyStimulus(1, 0, 1, 0, 12'h077, 148'h7_0000_0000_0000_0007);
        for (int i = 0; i < 4; i++) applyStimulus(1, 1, 0, 0, 12'h0FF, 148'd99);
        applyStimulus(0, 1, 1, 0, 12'h000, 148'd0);

        $display("[TB] flush while frozen");
        applyStimulus(1, 0, 1, 0, 12'h0CC, 148'd12);
        applyStimulus(0, 1, 0, 1, 12'h000, 148'd0);
        applyStimulus(0, 1, 1, 0, 12'h000, 148'd0);

        $display("[TB] idle bubbles");
        for (int i = 0; i < 5; i++) applyStimulus(0, 1, 1, 0, 12'h000, 148'd0);

        $display("[TB] async reset while full");
        applyStimulus(1, 0, 1, 0, 12'h099, 148'd9);
        applyStimulus(1, 0, 1, 0, 12'h0AA, 148'd10);
        asyncReset();
        applyStimulus(1, 1, 1, 0, 12'h0BB, 148'd11);
        applyStimulus(0, 1, 1, 0, 12'h000, 148'd0);
        applyStimulus(0, 1, 1, 0, 12'h000, 148'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Generic, parametrised inter-stage pipeline register, the successor to the fixed-field stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries a control bundle and a data bundle of configurable width.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream ready is registered while full throughput is kept.
- Adds synchronous flush (bubble insertion) and a debug-step enable.
- Instantiated once per stage boundary in the pipelined MIPS core.

Parameters:
- NB_CTRL, 12: width of the control bundle (reg_write, mem_to_reg, alu_op, ...). Zeroed on bubbles.
- NB_DATA, 148: width of the data bundle (pc, operands, immediate, shamt, rt, rd). Not zeroed on bubbles.
- NB_CNT, 16: width of the bubble counter (optional feature).

Ports:
- i_clock, input, 1: pipeline clock; all state updates on the rising edge.
- i_reset, input, 1: asynchronous, active-high reset.
- i_enable, input, 1: debug-unit step enable; 0 freezes the stage.
- i_flush, input, 1: synchronous flush from hazard/branch unit.
- i_valid, input, 1: upstream entry valid.
- o_ready, output, 1: stage can accept an entry.
- i_ctrl, input, NB_CTRL: upstream control bundle.
- i_data, input, NB_DATA: upstream data bundle.
- o_valid, output, 1: downstream entry valid.
- i_ready, input, 1: downstream accepts the entry.
- o_ctrl, output, NB_CTRL: control bundle to next stage.
- o_data, output, NB_DATA: data bundle to next stage.
- o_bubble_cnt, output, NB_CNT: bubble counter (optional feature).

Behaviour:
- Storage: main register (m_valid, m_ctrl, m_data) and skid register (s_valid, s_ctrl, s_data).
- State encoding: EMPTY (m_valid=0), ONE (m_valid=1, s_valid=0), FULL (both valid).
- Reset (async, i_reset=1):
  - State goes to EMPTY and all registers clear to 0 immediately.
  - o_valid=0, o_ctrl=0, o_data=0.
  - o_ready is forced to 0 while i_reset is high.
- Output equations:
  - o_ready = i_enable & ~s_valid & ~i_reset. It depends only on registered state plus enable.
  - o_valid = m_valid & i_enable.
  - o_ctrl = m_valid ? m_ctrl : 0 (bubble = nop control). o_data = m_data at all times.
- Transfers: acc = i_valid & o_ready; tak = o_valid & i_ready.
- Transitions, evaluated when i_enable=1 and i_flush=0:
  - EMPTY: acc → ONE, main ← input.
  - ONE, acc & tak → ONE, main ← input.
  - ONE, acc & ~tak → FULL, skid ← input.
  - ONE, ~acc & tak → EMPTY.
  - ONE, neither → ONE, hold.
  - FULL: tak → ONE, main ← skid, s_valid ← 0. No accept is possible because o_ready=0.
- Latency and ordering:
  - An accepted entry appears on o_valid exactly 1 cycle later when the stage is empty.
  - Entries leave in strict arrival order; there is no loss and no duplication.
- i_enable=0:
  - All state holds; o_valid=0 and o_ready=0, so no transfers occur.
  - Resuming restores the exact prior state.
- i_flush=1 (sync, highest priority after reset):
  - Next state is EMPTY; m_valid and s_valid clear to 0 and m_ctrl clears to 0.
  - Any entry accepted in the same cycle is discarded.
  - A downstream transfer in the flush cycle still completes.
  - o_ready is 1 on the next cycle if i_enable=1.
  - Flush acts even when i_enable=0.
- Reset asserted mid-operation: all entries are discarded and there is no partial update.

Optional Feature:
- Macro PIPE_STAGE_BUBBLE_CNT_EN.
- When defined:
  - o_bubble_cnt counts cycles with i_enable=1 and o_valid=0.
  - The counter saturates at 2^NB_CNT-1 and clears on reset.
  - It is not cleared by flush.
- When undefined:
  - The counter logic is absent and o_bubble_cnt is tied to 0.
  - The port list is identical in both builds.

Test Plan:
- Reset then stream: i_valid=1, i_ready=1, ctrl=0x0A5, data=1,2,3 on consecutive cycles → o_valid high from cycle 1; o_data 1,2,3 on consecutive cycles; o_ready stays 1.
- Backpressure: send 1,2,3 with i_ready=0 from cycle 1 → state FULL after entry 2, o_ready=0, entry 3 held off; i_ready=1 → outputs 1,2,3 in order with no loss.
- Flush while FULL (entries 5,6 held) → next cycle o_valid=0, o_ctrl=0, o_ready=1; entries 5 and 6 never appear at the output.
- Debug freeze: i_enable=0 for 4 cycles while ONE holds entry 7 → o_valid=0 and state unchanged; on i_enable=1, entry 7 is presented with the same ctrl/data.
- Async reset asserted mid-clock while FULL → outputs zero without waiting for a clock edge; o_ready=0 until i_reset is released, then 1.
- With PIPE_STAGE_BUBBLE_CNT_EN, NB_CNT=2: 5 idle enabled cycles → o_bubble_cnt=3 (saturated); without the macro it stays 0.
